// File: rtl/contrast_gain_pipe.sv
// contrast_gain_pipe: per-pixel linear contrast/brightness stage.
//   out = clamp(round(in * gain) + offset), applied to every channel of a
//   packed pixel. Three-stage valid/ready pipeline; all stages move together.
// Optional build macro: CONTRAST_SAT_STATS_EN adds a per-frame clamp counter
//   and the sat_count output.
// Ports:
//   clk, rst_n            pixel clock, asynchronous active-low reset
//   cfg_enable            1 = adjust, 0 = bypass
//   cfg_gain              gain, UQ(GAIN_W-FRAC_W).FRAC_W
//   cfg_offset            signed offset
//   s_valid/s_ready       input handshake (s_ready is combinational)
//   s_data, s_sof, s_eol  input pixel and sideband
//   m_valid/m_ready       output handshake
//   m_data, m_sof, m_eol  adjusted pixel and sideband
//   sat_count             (optional) clamp total of the previous frame
module contrast_gain_pipe #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned CH     = 3,
   parameter int unsigned GAIN_W = 8,
   parameter int unsigned FRAC_W = 4,
   parameter int unsigned OFFS_W = 9
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   cfg_enable,
   input  logic [GAIN_W-1:0]      cfg_gain,
   input  logic [OFFS_W-1:0]      cfg_offset,
   input  logic                   s_valid,
   output logic                   s_ready,
   input  logic [CH*DATA_W-1:0]   s_data,
   input  logic                   s_sof,
   input  logic                   s_eol,
   output logic                   m_valid,
   input  logic                   m_ready,
   output logic [CH*DATA_W-1:0]   m_data,
   output logic                   m_sof,
   output logic                   m_eol
`ifdef CONTRAST_SAT_STATS_EN
   ,
   output logic [31:0]            sat_count
`endif
);

   localparam int unsigned PW    = DATA_W + GAIN_W;
   localparam int unsigned SW    = DATA_W + GAIN_W + 2;
   localparam int unsigned PIX_W = CH * DATA_W;
   localparam logic [GAIN_W-1:0] GAIN_ONE = GAIN_W'(1) << FRAC_W;
   // Half an LSB of the fractional part; zero when there are no fraction bits.
   localparam logic [SW-1:0] RND  = (SW'(1) << FRAC_W) >> 1;
   localparam logic [SW-1:0] MAXV = {{(SW-DATA_W){1'b0}}, {DATA_W{1'b1}}};

   logic advance;
   logic accept;
   logic load_cfg;

   // Whole pipeline moves only when the output slot is free or being drained.
   assign advance  = !m_valid || m_ready;
   assign s_ready  = advance;
   assign accept   = s_valid && advance;
   assign load_cfg = accept && s_sof;

   // Active (shadow) coefficients, captured on an accepted start-of-frame beat.
   logic              act_en;
   logic [GAIN_W-1:0] act_gain;
   logic [OFFS_W-1:0] act_offs;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         act_en   <= 1'b0;
         act_gain <= GAIN_ONE;
         act_offs <= '0;
      end else if (load_cfg) begin
         act_en   <= cfg_enable;
         act_gain <= cfg_gain;
         act_offs <= cfg_offset;
      end
   end

   // The sof beat itself already uses the newly requested coefficients.
   logic              eff_en;
   logic [GAIN_W-1:0] eff_gain;
   logic [OFFS_W-1:0] eff_offs;

   assign eff_en   = load_cfg ? cfg_enable : act_en;
   assign eff_gain = load_cfg ? cfg_gain   : act_gain;
   assign eff_offs = load_cfg ? cfg_offset : act_offs;

   // S1: multiply; coefficients travel with the beat.
   logic                  s1_valid, s1_sof, s1_eol, s1_en;
   logic [PIX_W-1:0]      s1_data;
   logic [OFFS_W-1:0]     s1_offs;
   logic [CH-1:0][PW-1:0] s1_prod;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_sof   <= 1'b0;
         s1_eol   <= 1'b0;
         s1_en    <= 1'b0;
         s1_data  <= '0;
         s1_offs  <= '0;
         s1_prod  <= '0;
      end else if (advance) begin
         s1_valid <= s_valid;
         s1_sof   <= s_valid && s_sof;
         s1_eol   <= s_valid && s_eol;
         s1_en    <= eff_en;
         s1_data  <= s_data;
         s1_offs  <= eff_offs;
         for (int c = 0; c < CH; c++)
            s1_prod[c] <= PW'(s_data[c*DATA_W +: DATA_W]) * PW'(eff_gain);
      end
   end

   // S2 arithmetic: round half up, drop fraction, add sign-extended offset.
   logic [CH-1:0][SW-1:0] sum_c;
   logic [SW-1:0]         offs_ext_c;

   assign offs_ext_c = {{(SW-OFFS_W){s1_offs[OFFS_W-1]}}, s1_offs};

   always_comb begin
      sum_c = '0;
      for (int c = 0; c < CH; c++)
         sum_c[c] = ((SW'(s1_prod[c]) + RND) >> FRAC_W) + offs_ext_c;
   end

   logic                  s2_valid, s2_sof, s2_eol, s2_en;
   logic [PIX_W-1:0]      s2_data;
   logic [CH-1:0][SW-1:0] s2_sum;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid <= 1'b0;
         s2_sof   <= 1'b0;
         s2_eol   <= 1'b0;
         s2_en    <= 1'b0;
         s2_data  <= '0;
         s2_sum   <= '0;
      end else if (advance) begin
         s2_valid <= s1_valid;
         s2_sof   <= s1_sof;
         s2_eol   <= s1_eol;
         s2_en    <= s1_en;
         s2_data  <= s1_data;
         s2_sum   <= sum_c;
      end
   end

   // S3 clamp (sum is two's complement in SW bits); bypass passes input through.
   logic [PIX_W-1:0] out_c;

   always_comb begin
      out_c = s2_data;
      if (s2_en) begin
         for (int c = 0; c < CH; c++) begin
            if (s2_sum[c][SW-1])
               out_c[c*DATA_W +: DATA_W] = '0;
            else if (s2_sum[c] > MAXV)
               out_c[c*DATA_W +: DATA_W] = '1;
            else
               out_c[c*DATA_W +: DATA_W] = s2_sum[c][DATA_W-1:0];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_valid <= 1'b0;
         m_sof   <= 1'b0;
         m_eol   <= 1'b0;
         m_data  <= '0;
      end else if (advance) begin
         m_valid <= s2_valid;
         m_sof   <= s2_sof;
         m_eol   <= s2_eol;
         m_data  <= out_c;
      end
   end

`ifdef CONTRAST_SAT_STATS_EN
   localparam int unsigned CNT_W = $clog2(CH + 1);

   logic [CNT_W-1:0] nsat_c;
   logic [CNT_W-1:0] m_nsat;
   logic [31:0]      frame_cnt;

   // Number of channels clamped (either direction) in the beat entering S3.
   always_comb begin
      nsat_c = '0;
      if (s2_en) begin
         for (int c = 0; c < CH; c++)
            if (s2_sum[c][SW-1] || (s2_sum[c] > MAXV))
               nsat_c = nsat_c + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         m_nsat <= '0;
      else if (advance)
         m_nsat <= s2_valid ? nsat_c : '0;
   end

   // Frame counter restarts on the output sof beat; total of the frame before it is latched.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_cnt <= '0;
         sat_count <= '0;
      end else if (m_valid && m_ready) begin
         if (m_sof) begin
            sat_count <= frame_cnt;
            frame_cnt <= 32'(m_nsat);
         end else begin
            frame_cnt <= frame_cnt + 32'(m_nsat);
         end
      end
   end
`endif

endmodule

// File: tb/tb_contrast_gain_pipe.sv
// tb_contrast_gain_pipe: directed bench for contrast_gain_pipe (default parameters).
// Expected pixels are hand-computed and queued; a monitor compares every output
// transfer in order and checks that output holds steady while stalled.
module tb_contrast_gain_pipe;

   localparam int unsigned DATA_W = 8;
   localparam int unsigned CH     = 3;
   localparam int unsigned GAIN_W = 8;
   localparam int unsigned OFFS_W = 9;
   localparam int unsigned PIX_W  = CH * DATA_W;

   typedef struct packed {
      logic             sof;
      logic             eol;
      logic [PIX_W-1:0] data;
   } beat_t;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              cfg_enable;
   logic [GAIN_W-1:0] cfg_gain;
   logic [OFFS_W-1:0] cfg_offset;
   logic              s_valid;
   logic              s_ready;
   logic [PIX_W-1:0]  s_data;
   logic              s_sof;
   logic              s_eol;
   logic              m_valid;
   logic              m_ready;
   logic [PIX_W-1:0]  m_data;
   logic              m_sof;
   logic              m_eol;
`ifdef CONTRAST_SAT_STATS_EN
   logic [31:0]       sat_count;
`endif

   contrast_gain_pipe dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cfg_enable (cfg_enable),
      .cfg_gain   (cfg_gain),
      .cfg_offset (cfg_offset),
      .s_valid    (s_valid),
      .s_ready    (s_ready),
      .s_data     (s_data),
      .s_sof      (s_sof),
      .s_eol      (s_eol),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .m_data     (m_data),
      .m_sof      (m_sof),
      .m_eol      (m_eol)
`ifdef CONTRAST_SAT_STATS_EN
      ,
      .sat_count  (sat_count)
`endif
   );

   always #5 clk = ~clk;

   int    n_total = 0;
   int    n_bad   = 0;
   beat_t exp_q[$];
   logic  rdy_pat = 1'b0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_total++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s got=%0h want=%0h", tag, got, want);
      end
   endtask

   function automatic logic [PIX_W-1:0] px(input logic [7:0] c0, input logic [7:0] c1,
                                           input logic [7:0] c2);
      return {c2, c1, c0};
   endfunction

   task automatic expect_beat(input logic [PIX_W-1:0] d, input logic sof, input logic eol);
      beat_t b;
      b.sof  = sof;
      b.eol  = eol;
      b.data = d;
      exp_q.push_back(b);
   endtask

   // Present one beat and hold it until accepted; returns just after the accepting edge.
   task automatic send(input logic [PIX_W-1:0] d, input logic sof, input logic eol);
      int   n;
      logic acc;
      n   = 0;
      acc = 1'b0;
      s_valid = 1'b1;
      s_data  = d;
      s_sof   = sof;
      s_eol   = eol;
      while (!acc && n < 100) begin
         @(negedge clk);
         acc = s_ready;
         @(posedge clk);
         #1;
         n++;
      end
      if (!acc) chk("send_timeout", 64'(acc), 64'd1);
      s_valid = 1'b0;
      s_sof   = 1'b0;
      s_eol   = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 300) begin
         @(posedge clk);
         n++;
      end
      #1;
      if (exp_q.size() != 0) chk("drain_timeout", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
   endtask

   // Downstream ready: always 1, or the repeating 1,0,0,1 pattern.
   initial begin
      logic [3:0] pat;
      int         idx;
      pat = 4'b1001;
      idx = 0;
      m_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (rdy_pat) begin
            m_ready = pat[idx];
            idx = (idx + 1) % 4;
         end else begin
            m_ready = 1'b1;
            idx = 0;
         end
      end
   end

   // Output monitor: in-order scoreboard plus stall-stability check.
   initial begin
      logic             hold_pend;
      logic [PIX_W+1:0] held;
      beat_t            e;
      hold_pend = 1'b0;
      held      = '0;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (hold_pend) chk("hold", 64'({m_sof, m_eol, m_data}), 64'(held));
            if (m_valid && m_ready) begin
               if (exp_q.size() == 0) begin
                  chk("extra_beat", 64'(m_data), 64'hdead);
               end else begin
                  e = exp_q.pop_front();
                  chk("data", 64'(m_data), 64'(e.data));
                  chk("sof", 64'(m_sof), 64'(e.sof));
                  chk("eol", 64'(m_eol), 64'(e.eol));
               end
            end
            hold_pend = m_valid && !m_ready;
            held      = {m_sof, m_eol, m_data};
         end else begin
            hold_pend = 1'b0;
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n      = 1'b0;
      cfg_enable = 1'b0;
      cfg_gain   = 8'h10;
      cfg_offset = '0;
      s_valid    = 1'b0;
      s_data     = '0;
      s_sof      = 1'b0;
      s_eol      = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_m_valid", 64'(m_valid), 64'd0);
      chk("rst_m_data", 64'(m_data), 64'd0);
      chk("rst_m_sof_eol", 64'({m_sof, m_eol}), 64'd0);
      chk("rst_s_ready", 64'(s_ready), 64'd1);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Gain 1.5, exact 3-cycle latency.
      cfg_enable = 1'b1;
      cfg_gain   = 8'h18;
      cfg_offset = 9'd0;
      expect_beat(px(8'd150, 8'd255, 8'd0), 1'b1, 1'b1);
      s_valid = 1'b1;
      s_data  = px(8'd100, 8'd200, 8'd0);
      s_sof   = 1'b1;
      s_eol   = 1'b1;
      @(posedge clk);
      #1;
      s_valid = 1'b0;
      s_sof   = 1'b0;
      s_eol   = 1'b0;
      chk("lat_c1", 64'(m_valid), 64'd0);
      @(posedge clk);
      #1;
      chk("lat_c2", 64'(m_valid), 64'd0);
      @(posedge clk);
      #1;
      chk("lat_c3", 64'(m_valid), 64'd1);
      chk("lat_data", 64'(m_data), 64'(px(8'd150, 8'd255, 8'd0)));
      chk("lat_sof", 64'(m_sof), 64'd1);
      drain();

      // Rounding half up at gain 1.5.
      expect_beat(px(8'd2, 8'd5, 8'd8), 1'b1, 1'b0);
      send(px(8'd1, 8'd3, 8'd5), 1'b1, 1'b0);
      drain();

      // Negative offset with low clamp, positive offset with high clamp.
      cfg_gain   = 8'h10;
      cfg_offset = 9'h1EC;
      expect_beat(px(8'd0, 8'd10, 8'd235), 1'b1, 1'b0);
      send(px(8'd10, 8'd30, 8'd255), 1'b1, 1'b0);
      drain();
      cfg_offset = 9'd20;
      expect_beat(px(8'd255, 8'd20, 8'd20), 1'b1, 1'b0);
      send(px(8'd250, 8'd0, 8'd0), 1'b1, 1'b0);
      drain();

      // Gain 0 gives clamp(offset).
      cfg_gain = 8'h00;
      expect_beat(px(8'd20, 8'd20, 8'd20), 1'b1, 1'b0);
      send(px(8'd77, 8'd0, 8'd255), 1'b1, 1'b0);
      drain();

      // 16-beat stream under 1,0,0,1 backpressure, gain 2.0 offset 5.
      cfg_gain   = 8'h20;
      cfg_offset = 9'd5;
      rdy_pat    = 1'b1;
      for (int i = 0; i < 16; i++)
         expect_beat(px(8'(14*i + 5), 8'(2*i + 5), 8'd255), i == 0, i == 15);
      for (int i = 0; i < 16; i++)
         send(px(8'(7*i), 8'(i), 8'(200 + i)), i == 0, i == 15);
      drain();
      rdy_pat = 1'b0;
      @(posedge clk);
      #1;

      // Mid-frame gain change waits for the next sof.
      cfg_gain   = 8'h10;
      cfg_offset = 9'd0;
      expect_beat(px(8'd60, 8'd60, 8'd60), 1'b1, 1'b0);
      expect_beat(px(8'd60, 8'd60, 8'd60), 1'b0, 1'b1);
      expect_beat(px(8'd120, 8'd120, 8'd120), 1'b1, 1'b0);
      send(px(8'd60, 8'd60, 8'd60), 1'b1, 1'b0);
      cfg_gain = 8'h20;
      send(px(8'd60, 8'd60, 8'd60), 1'b0, 1'b1);
      send(px(8'd60, 8'd60, 8'd60), 1'b1, 1'b0);
      drain();

      // Bypass: data unchanged regardless of gain/offset.
      cfg_enable = 1'b0;
      cfg_gain   = 8'h30;
      cfg_offset = 9'd100;
      expect_beat(px(8'd17, 8'd99, 8'd250), 1'b1, 1'b0);
      send(px(8'd17, 8'd99, 8'd250), 1'b1, 1'b0);
      drain();

      // Reset during an active stream.
      cfg_enable = 1'b1;
      cfg_gain   = 8'h20;
      cfg_offset = 9'd0;
      send(px(8'd10, 8'd10, 8'd10), 1'b1, 1'b0);
      send(px(8'd11, 8'd11, 8'd11), 1'b0, 1'b0);
      send(px(8'd12, 8'd12, 8'd12), 1'b0, 1'b0);
      rst_n = 1'b0;
      #1;
      chk("midrst_m_valid", 64'(m_valid), 64'd0);
      chk("midrst_m_data", 64'(m_data), 64'd0);
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      cfg_offset = 9'd50;
      expect_beat(px(8'd33, 8'd66, 8'd99), 1'b0, 1'b0);
      send(px(8'd33, 8'd66, 8'd99), 1'b0, 1'b0);
      drain();
      expect_beat(px(8'd116, 8'd182, 8'd248), 1'b1, 1'b0);
      send(px(8'd33, 8'd66, 8'd99), 1'b1, 1'b0);
      drain();

`ifdef CONTRAST_SAT_STATS_EN
      // Frame with 5 clamped channels, then a sof beat latches the total.
      cfg_enable = 1'b1;
      cfg_gain   = 8'h10;
      cfg_offset = 9'h1EC;
      expect_beat(px(8'd0, 8'd10, 8'd235), 1'b1, 1'b0);
      expect_beat(px(8'd0, 8'd0, 8'd0), 1'b0, 1'b0);
      expect_beat(px(8'd0, 8'd80, 8'd80), 1'b0, 1'b0);
      expect_beat(px(8'd80, 8'd80, 8'd80), 1'b0, 1'b1);
      expect_beat(px(8'd80, 8'd80, 8'd80), 1'b1, 1'b0);
      send(px(8'd10, 8'd30, 8'd255), 1'b1, 1'b0);
      send(px(8'd0, 8'd0, 8'd0), 1'b0, 1'b0);
      send(px(8'd5, 8'd100, 8'd100), 1'b0, 1'b0);
      send(px(8'd100, 8'd100, 8'd100), 1'b0, 1'b1);
      send(px(8'd100, 8'd100, 8'd100), 1'b1, 1'b0);
      drain();
      chk("sat_count", 64'(sat_count), 64'd5);
`endif

      repeat (3) @(posedge clk);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
